cpu7_exu_eclrdpipe: RTL

- Destination-register pipeline tracker for the EXU control logic.
- Carries rd/wen/load attributes of each instruction from decode through the E, M and W stages.
- Drives the rd_m/rd_w/wen_m/wen_w inputs of the rs1/rs2 bypass-select logic.
- Detects load-use hazards and stalls decode until the load result can be bypassed from W.

---
 rtl/cpu7_exu_eclrdpipe.sv | 106 ++++++++++
 1 files changed

// File: rtl/cpu7_exu_eclrdpipe.sv
// Destination-register tracker for the E/M/W stages of the EXU.
// Feeds the bypass selects and raises the load-use decode interlock.
module cpu7_exu_eclrdpipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             de_valid,
  input  logic [4:0]       de_rd,
  input  logic             de_wen,
  input  logic             de_load,
  input  logic [4:0]       de_rs1,
  input  logic             de_rs1_used,
  input  logic [4:0]       de_rs2,
  input  logic             de_rs2_used,
  input  logic             mem_stall,
  input  logic             flush_d,
  input  logic             flush_em,
  output logic [4:0]       rd_e,
  output logic             wen_e,
  output logic [4:0]       rd_m,
  output logic             wen_m,
  output logic [4:0]       rd_w,
  output logic             wen_w,
  output logic             stall_d,
  output logic [CNT_W-1:0] lduse_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
  } stg_t;

  stg_t             r_e;
  stg_t             r_m;
  stg_t             r_w;
  stg_t             w_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  function automatic logic hit(
    input logic       used,
    input logic [4:0] rs,
    input stg_t       s
  );
    return used & (rs != 5'd0) & s.v & s.ld & (rs == s.rd);
  endfunction

  // A load in W is served by the W bypass, so only E and M interlock.
  assign w_hit = hit(de_rs1_used, de_rs1, r_e)
               | hit(de_rs1_used, de_rs1, r_m)
               | hit(de_rs2_used, de_rs2, r_e)
               | hit(de_rs2_used, de_rs2, r_m);

  assign stall_d = de_valid & w_hit;

  always_comb begin
    w_d     = '0;
    w_d.v   = de_valid & ~flush_d & ~stall_d;
    w_d.rd  = de_rd;
    w_d.wen = de_wen;
    w_d.ld  = de_load;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else if (mem_stall) begin
      if (flush_em) begin
        r_e.v <= 1'b0;
        r_m.v <= 1'b0;
      end
    end else begin
      r_w <= r_m;
      r_m <= r_e;
      r_e <= w_d;
      // Killed E/M contents must not reach M or W.
      if (flush_em) begin
        r_e.v <= 1'b0;
        r_m.v <= 1'b0;
        r_w.v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (stall_d & ~mem_stall & ~flush_em & ~(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rd_e      = r_e.rd;
  assign rd_m      = r_m.rd;
  assign rd_w      = r_w.rd;
  assign wen_e     = r_e.v & r_e.wen & (r_e.rd != 5'd0);
  assign wen_m     = r_m.v & r_m.wen & (r_m.rd != 5'd0);
  assign wen_w     = r_w.v & r_w.wen & (r_w.rd != 5'd0);
  assign lduse_cnt = r_cnt;

endmodule
